// File: rtl/qft3_ctrl_pkg.sv
// Shared definitions for the 3-qubit QFT streaming controller:
// amplitude width, packed vector width, lane helper and FSM state encodings.
package qft3_ctrl_pkg;

   // S3.4 signed fixed point: 1 sign, 3 integer, 4 fractional bits
   localparam int TOTAL_WIDTH = 8;
   localparam int VEC_W       = 16 * TOTAL_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } ctrl_state_t;

   // LSB position of lane j in a packed vector (lane 2n = re, 2n+1 = im of |n>)
   function automatic int lane_lsb(input int j);
      return j * TOTAL_WIDTH;
   endfunction

endpackage

// File: rtl/qft3_result_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Push and pop may coincide at any occupancy, including full.
module qft3_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count   = wptr - rptr;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/qft3_stream_ctrl.sv
// Streaming controller around the free-running pipelined 3-qubit QFT datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no admission; start -> ST_RUN
//   ST_RUN   | accept vectors while credits remain; flush -> ST_DRAIN
//   ST_DRAIN | no admission; wait for delay line and FIFO to empty, pulse done
module qft3_stream_ctrl
   import qft3_ctrl_pkg::*;
#(
   parameter int PIPE_LAT   = 19,
   parameter int FIFO_DEPTH = 32,
   parameter int W          = TOTAL_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [16*W-1:0]               in_vec,
   output logic [16*W-1:0]               pipe_in,
   input  logic [16*W-1:0]               pipe_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [16*W-1:0]               out_vec,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(PIPE_LAT+2)-1:0] inflight,
   output logic [15:0]                   jobs_done
);

   localparam int IFW = $clog2(PIPE_LAT + 2);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int SW  = ((IFW > CW) ? IFW : CW) + 1;

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic [PIPE_LAT:0] tags;
   logic [CW-1:0]    fifo_count;
   logic [SW-1:0]    credit_used;
   logic             credit_ok;
   logic             fifo_empty;
   logic             issue;
   logic             capture;
   logic             pop;
   logic             done_set;

   // Every in-flight tag and every queued result holds one FIFO slot; a
   // same-cycle pop is deliberately not counted back as credit.
   assign credit_used = SW'(inflight) + SW'(fifo_count);
   assign credit_ok   = credit_used < SW'(FIFO_DEPTH);

   assign issue     = in_valid && in_ready;
   assign capture   = tags[PIPE_LAT];
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            in_ready = credit_ok;
            if (flush) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((inflight == '0) && fifo_empty) begin
               state_nxt = ST_IDLE;
               done_set  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         done      <= 1'b0;
         tags      <= '0;
         pipe_in   <= '0;
         inflight  <= '0;
         jobs_done <= '0;
      end else begin
         state   <= state_nxt;
         done    <= done_set;
         tags    <= {tags[PIPE_LAT-1:0], issue};
         pipe_in <= issue ? in_vec : '0;
         if (issue && !capture)      inflight <= inflight + IFW'(1);
         else if (!issue && capture) inflight <= inflight - IFW'(1);
         if (pop) jobs_done <= jobs_done + 16'd1;
      end
   end

   qft3_result_fifo #(
      .WIDTH (16 * W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .din   (pipe_out),
      .pop   (pop),
      .dout  (out_vec),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_qft3_stream_ctrl.sv
// Bench for qft3_stream_ctrl: behavioural datapath stand-in (19-cycle delay,
// optional floating-point QFT), scenario tasks with randomized vectors.
`timescale 1ns/1ps
module tb_qft3_stream_ctrl;
   import qft3_ctrl_pkg::*;

   localparam int PIPE_LAT   = 19;
   localparam int FIFO_DEPTH = 32;
   localparam int W          = TOTAL_WIDTH;
   localparam int VW         = 16 * W;
   localparam int IFW        = $clog2(PIPE_LAT + 2);
   localparam int LAT        = PIPE_LAT + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [VW-1:0] in_vec = '0;
   logic [VW-1:0] pipe_in;
   logic [VW-1:0] pipe_out;
   logic [VW-1:0] out_vec;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic          done;
   logic [IFW-1:0] inflight;
   logic [15:0]   jobs_done;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit qft_mode = 1'b0;

   logic [VW-1:0] dl [PIPE_LAT];
   logic [VW-1:0] exp_q[$];
   logic [VW-1:0] got_q[$];
   int            hs_cyc_q[$];
   int            pop_cyc_q[$];

   qft3_stream_ctrl #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .pipe_in(pipe_in), .pipe_out(pipe_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .busy(busy), .done(done), .inflight(inflight), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal QFT: out_k = 1/sqrt(8) * sum_n x_n * exp(+2*pi*i*n*k/8)
   function automatic logic [VW-1:0] qft_ref(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      real sr, si, xr, xi, a;
      int t, ir, ii;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 8; n++) begin
            t  = $signed(v[lane_lsb(2*n) +: W]);
            xr = t;
            t  = $signed(v[lane_lsb(2*n+1) +: W]);
            xi = t;
            a  = 2.0 * 3.14159265358979 * n * k / 8.0;
            sr = sr + xr * $cos(a) - xi * $sin(a);
            si = si + xr * $sin(a) + xi * $cos(a);
         end
         sr = sr / $sqrt(8.0);
         si = si / $sqrt(8.0);
         ir = (sr >= 0.0) ? $rtoi(sr + 0.5) : -$rtoi(-sr + 0.5);
         ii = (si >= 0.0) ? $rtoi(si + 0.5) : -$rtoi(-si + 0.5);
         r[lane_lsb(2*k) +: W]   = W'(ir);
         r[lane_lsb(2*k+1) +: W] = W'(ii);
      end
      return r;
   endfunction

   // Datapath stand-in, shares rst_n like the real pipeline
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) dl[i] <= '0;
      end else begin
         dl[0] <= qft_mode ? qft_ref(pipe_in) : pipe_in;
         for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
      end
   end
   assign pipe_out = dl[PIPE_LAT-1];

   // Handshake recorder and FIFO overflow assertion
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(in_vec);
            hs_cyc_q.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            got_q.push_back(out_vec);
            pop_cyc_q.push_back(cyc);
         end
         if (done) done_cnt++;
         compared++;
         if (dut.capture && (dut.fifo_count == FIFO_DEPTH) && !(out_valid && out_ready)) begin
            mismatched++;
            $display("FAIL fifo_overflow cyc=%0d count=%0d required below %0d", cyc, dut.fifo_count, FIFO_DEPTH);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int j = 0; j < 16; j++) v[lane_lsb(j) +: W] = W'($urandom());
      return v;
   endfunction

   function automatic logic [VW-1:0] mk(input int id);
      logic [VW-1:0] v;
      v = rand_vec();
      v[lane_lsb(0) +: W] = W'(id);
      return v;
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_queues();
      exp_q.delete();
      got_q.delete();
      hs_cyc_q.delete();
      pop_cyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
      repeat (2) next();
      clear_queues();
      rst_n = 1'b1;
      next();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      next();
      start = 1'b0;
   endtask

   task automatic test_reset();
      in_vec = rand_vec();
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
      compared++; if (inflight !== '0) begin mismatched++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
      compared++; if (jobs_done !== 16'd0) begin mismatched++; $display("FAIL reset_jobs_done got=%0d want=0", jobs_done); end
      compared++; if (pipe_in !== '0) begin mismatched++; $display("FAIL reset_pipe_in got=%h want=0", pipe_in); end
   endtask

   task automatic test_single_vector(input bit use_qft);
      logic [VW-1:0] v;
      int guard, lat, gr, gi;
      int exp_re [8] = '{6, 0, -6, 0, 6, 0, -6, 0};
      int exp_im [8] = '{0, -6, 0, 6, 0, -6, 0, 6};
      qft_mode  = use_qft;
      out_ready = 1'b1;
      if (use_qft) begin
         v = '0;
         v[lane_lsb(12) +: W] = W'(16);
      end else begin
         v = mk(77);
      end
      pulse_start();
      in_vec = v;
      in_valid = 1'b1;
      guard = 0;
      while (exp_q.size() == 0 && guard < 5) begin next(); guard++; end
      in_valid = 1'b0;
      compared++;
      if (exp_q.size() != 1) begin
         mismatched++; $display("FAIL single_accept got=%0d handshakes want=1", exp_q.size());
         return;
      end
      compared++; if (pipe_in !== v) begin mismatched++; $display("FAIL single_pipe_in got=%h want=%h", pipe_in, v); end
      guard = 0;
      while (got_q.size() == 0 && guard < 40) begin next(); guard++; end
      compared++;
      if (got_q.size() == 0) begin
         mismatched++; $display("FAIL single_timeout got=no out_valid want=result within 40 cycles");
         return;
      end
      lat = pop_cyc_q[0] - hs_cyc_q[0];
      compared++; if (lat != LAT) begin mismatched++; $display("FAIL single_latency got=%0d want=%0d", lat, LAT); end
      if (use_qft) begin
         for (int n = 0; n < 8; n++) begin
            gr = $signed(got_q[0][lane_lsb(2*n) +: W]);
            gi = $signed(got_q[0][lane_lsb(2*n+1) +: W]);
            compared++;
            if (gr < exp_re[n] - 2 || gr > exp_re[n] + 2 || gi < exp_im[n] - 2 || gi > exp_im[n] + 2) begin
               mismatched++;
               $display("FAIL single_qft_amp%0d got=(%0d,%0d) want=(%0d,%0d)+-2", n, gr, gi, exp_re[n], exp_im[n]);
            end
         end
      end else begin
         compared++; if (got_q[0] !== v) begin mismatched++; $display("FAIL single_data got=%h want=%h", got_q[0], v); end
      end
      flush = 1'b1;
      next();
      flush = 1'b0;
      guard = 0;
      while (busy && guard < 40) begin next(); guard++; end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_return_idle got busy=%b want=0", busy); end
      qft_mode = 1'b0;
   endtask

   task automatic test_stream();
      int sent, drops, guard;
      out_ready = 1'b1;
      pulse_start();
      sent = 0; drops = 0; guard = 0;
      in_valid = 1'b1;
      while (sent < 40 && guard < 200) begin
         if (in_ready !== 1'b1) drops++;
         in_vec = mk(sent);
         next();
         guard++;
         sent = exp_q.size();
      end
      in_valid = 1'b0;
      compared++; if (drops != 0) begin mismatched++; $display("FAIL stream_in_ready_drops got=%0d want=0", drops); end
      compared++; if (sent != 40) begin mismatched++; $display("FAIL stream_accepted got=%0d want=40", sent); end
      guard = 0;
      while (got_q.size() < sent && guard < 100) begin next(); guard++; end
      compared++; if (got_q.size() != 40) begin mismatched++; $display("FAIL stream_results got=%0d want=40", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i] || got_q[i][W-1:0] !== W'(i)) begin
            mismatched++; $display("FAIL stream_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
         end
         compared++;
         if (pop_cyc_q[i] - hs_cyc_q[i] != LAT) begin
            mismatched++; $display("FAIL stream_latency[%0d] got=%0d want=%0d", i, pop_cyc_q[i] - hs_cyc_q[i], LAT);
         end
      end
      compared++; if (jobs_done !== 16'd40) begin mismatched++; $display("FAIL stream_jobs_done got=%0d want=40", jobs_done); end
   endtask

   task automatic test_backpressure();
      int guard;
      out_ready = 1'b0;
      pulse_start();
      in_valid = 1'b1;
      repeat (80) begin
         in_vec = mk(exp_q.size());
         next();
      end
      compared++; if (exp_q.size() != FIFO_DEPTH) begin mismatched++; $display("FAIL bp_accepted got=%0d want=%0d", exp_q.size(), FIFO_DEPTH); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
      compared++; if (inflight !== '0) begin mismatched++; $display("FAIL bp_inflight got=%0d want=0", inflight); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (got_q.size() < exp_q.size() && guard < 80) begin next(); guard++; end
      compared++; if (got_q.size() != FIFO_DEPTH) begin mismatched++; $display("FAIL bp_results got=%0d want=%0d", got_q.size(), FIFO_DEPTH); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i] || got_q[i][W-1:0] !== W'(i)) begin
            mismatched++; $display("FAIL bp_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
         end
      end
      compared++; if (jobs_done !== 16'd32) begin mismatched++; $display("FAIL bp_jobs_done got=%0d want=32", jobs_done); end
   endtask

   task automatic test_flush();
      int guard, idle_acc;
      bit seen;
      out_ready = 1'b1;
      pulse_start();
      in_valid = 1'b1;
      guard = 0;
      while (exp_q.size() < 5 && guard < 20) begin
         in_vec = mk(exp_q.size());
         flush = (exp_q.size() == 4) && in_ready;
         next();
         guard++;
      end
      flush = 1'b0;
      in_valid = 1'b0;
      compared++; if (exp_q.size() != 5) begin mismatched++; $display("FAIL flush_accepted got=%0d want=5", exp_q.size()); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL flush_drain_busy got=%b want=1", busy); end
      seen = 1'b0;
      guard = 0;
      while (!seen && guard < 60) begin
         next();
         guard++;
         if (done) begin
            seen = 1'b1;
            compared++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
               mismatched++; $display("FAIL flush_done_idle got busy=%b in_ready=%b want 0/0", busy, in_ready);
            end
         end
      end
      compared++; if (!seen) begin mismatched++; $display("FAIL flush_done_timeout got=no done want=done pulse"); end
      in_valid = 1'b1;
      in_vec = rand_vec();
      idle_acc = 0;
      repeat (5) begin
         if (in_ready !== 1'b0) idle_acc++;
         next();
      end
      in_valid = 1'b0;
      compared++; if (idle_acc != 0 || exp_q.size() != 5) begin mismatched++; $display("FAIL flush_idle_in_ready got=%0d ready cycles want=0", idle_acc); end
      compared++; if (done_cnt != 1) begin mismatched++; $display("FAIL flush_done_count got=%0d want=1", done_cnt); end
      compared++; if (got_q.size() != 5) begin mismatched++; $display("FAIL flush_results got=%0d want=5", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         compared++;
         if (got_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL flush_order[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_midflight();
      int guard, bad;
      out_ready = 1'b1;
      pulse_start();
      in_valid = 1'b1;
      guard = 0;
      while (exp_q.size() < 10 && guard < 30) begin
         in_vec = mk(exp_q.size());
         next();
         guard++;
      end
      in_valid = 1'b0;
      repeat (3) next();
      rst_n = 1'b0;
      #2;
      compared++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          inflight !== '0 || jobs_done !== 16'd0 || pipe_in !== '0) begin
         mismatched++;
         $display("FAIL midreset_outputs got ready=%b valid=%b busy=%b done=%b inflight=%0d jobs=%0d pipe_in=%h want all zero",
                  in_ready, out_valid, busy, done, inflight, jobs_done, pipe_in);
      end
      next();
      clear_queues();
      rst_n = 1'b1;
      bad = 0;
      repeat (40) begin
         next();
         if (out_valid !== 1'b0 || inflight !== '0) bad++;
      end
      compared++; if (bad != 0 || got_q.size() != 0) begin mismatched++; $display("FAIL midreset_stale got=%0d bad cycles want=0", bad); end
      test_single_vector(1'b0);
   endtask

   task automatic test_idle_bubbles();
      int bad;
      pulse_start();
      in_valid = 1'b0;
      bad = 0;
      repeat (30) begin
         in_vec = rand_vec();
         next();
         if (pipe_in !== '0 || inflight !== '0) bad++;
      end
      compared++; if (bad != 0) begin mismatched++; $display("FAIL bubbles got=%0d nonzero cycles want=0", bad); end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bubbles_in_ready got=%b want=1", in_ready); end
   endtask

   initial begin
      do_reset();
      test_reset();
      do_reset();
      test_single_vector(1'b1);
      do_reset();
      test_stream();
      do_reset();
      test_backpressure();
      do_reset();
      test_flush();
      do_reset();
      test_reset_midflight();
      do_reset();
      test_idle_bubbles();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
